// File: rtl/ctrl_sequencer_if.sv
// ----------------------------------------------------------------------------
// ctrl_sequencer_if
//   Bundles everything the control sequencer exchanges with the decoder and
//   the datapath: the start level, the decoder's one-hot flags, the ALU gt
//   flag, the datapath strobes and the status lines.
//   Modports:
//     slave  - the sequencer: flags/start/gt in, strobes/status out
//     master - the surrounding system: drives flags/start/gt, sees strobes
// ----------------------------------------------------------------------------
interface ctrl_sequencer_if;
    logic       start;
    logic       mova, movb, movc, movd;
    logic       add, sub, jmp, jg;
    logic       in1, out1, movi, halt;
    logic       gt;
    logic       dec_en;
    logic       pc_clr, pc_inc, pc_ld;
    logic       mar_ld, mem_rd;
    logic       ir_ld, imm_ld;
    logic       reg_we;
    logic [1:0] reg_sel;
    logic       alu_oe, alu_sub, flag_ld;
    logic       in_oe, imm_oe, out_ld;
    logic       busy, halted, illegal;

    modport slave (
        input  start, mova, movb, movc, movd, add, sub, jmp, jg,
               in1, out1, movi, halt, gt,
        output dec_en, pc_clr, pc_inc, pc_ld, mar_ld, mem_rd, ir_ld, imm_ld,
               reg_we, reg_sel, alu_oe, alu_sub, flag_ld, in_oe, imm_oe,
               out_ld, busy, halted, illegal
    );

    modport master (
        output start, mova, movb, movc, movd, add, sub, jmp, jg,
               in1, out1, movi, halt, gt,
        input  dec_en, pc_clr, pc_inc, pc_ld, mar_ld, mem_rd, ir_ld, imm_ld,
               reg_we, reg_sel, alu_oe, alu_sub, flag_ld, in_oe, imm_oe,
               out_ld, busy, halted, illegal
    );
endinterface

// File: rtl/ctrl_sequencer.sv
// ----------------------------------------------------------------------------
// ctrl_sequencer
//   Fetch/decode/execute control sequencer for the 4-bit-opcode model
//   machine. Enables the instruction decoder for one cycle per instruction,
//   latches its one-hot flags and turns them into datapath strobes.
//   Ports:
//     clk  - system clock, rising edge
//     rst  - asynchronous reset, active-high
//     step - (SEQ_SINGLE_STEP_EN only) single-step request, rising edge
//     bus  - ctrl_sequencer_if.slave: start, decoder flags, gt in;
//            PC/MAR/memory/IR/regfile/ALU/IO strobes and status out
//   Parameter:
//     MEM_WAIT - extra cycles mem_rd is held before ir_ld/imm_ld (0..7)
//   Optional feature:
//     SEQ_SINGLE_STEP_EN - adds the step port and a WAIT state after EXEC
// ----------------------------------------------------------------------------
module ctrl_sequencer #(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic            clk,
    input  logic            rst,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic            step,
`endif
    ctrl_sequencer_if.slave bus
);
    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

    // Bit positions of the decoder flags inside the flag vector / op_r.
    localparam int OP_MOVA = 0;
    localparam int OP_MOVB = 1;
    localparam int OP_MOVC = 2;
    localparam int OP_MOVD = 3;
    localparam int OP_ADD  = 4;
    localparam int OP_SUB  = 5;
    localparam int OP_JMP  = 6;
    localparam int OP_JG   = 7;
    localparam int OP_IN1  = 8;
    localparam int OP_OUT1 = 9;
    localparam int OP_MOVI = 10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LATCH  = 3'd2,
        S_DECODE = 3'd3,
        S_OPND   = 3'd4,
        S_EXEC   = 3'd5,
        S_HALT   = 3'd6
`ifdef SEQ_SINGLE_STEP_EN
        , S_WAIT = 3'd7
`endif
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [10:0] op_r;
    logic [2:0]  wait_r;
    logic [11:0] flags_s;
    logic [3:0]  flag_cnt_s;
    logic        mem_last_s;
    logic        has_opnd_s;
    logic        step_edge_s;

    function automatic logic [3:0] count_flags(input logic [11:0] f);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 12; i++) begin
            n = n + {3'd0, f[i]};
        end
        return n;
    endfunction

    assign flags_s    = {bus.halt, bus.movi, bus.out1, bus.in1, bus.jg, bus.jmp,
                         bus.sub, bus.add, bus.movd, bus.movc, bus.movb, bus.mova};
    assign flag_cnt_s = count_flags(flags_s);
    assign mem_last_s = (wait_r == WAIT_LAST);
    assign has_opnd_s = flags_s[OP_JMP] | flags_s[OP_JG] | flags_s[OP_MOVI];

`ifdef SEQ_SINGLE_STEP_EN
    logic step_r;

    // Previous step level for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_r <= 1'b0;
        end else begin
            step_r <= step;
        end
    end

    assign step_edge_s = step & ~step_r;
`else
    assign step_edge_s = 1'b0;
`endif

    // State register, latched opcode and memory wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            op_r    <= 11'd0;
            wait_r  <= 3'd0;
        end else begin
            state_r <= state_s;
            if (state_r == S_DECODE) begin
                op_r <= flags_s[10:0];
            end else begin
                op_r <= op_r;
            end
            // Counts mem_rd cycles; cleared on the last one so OPND starts fresh.
            if ((state_r == S_LATCH || state_r == S_OPND) && !mem_last_s) begin
                wait_r <= wait_r + 3'd1;
            end else begin
                wait_r <= 3'd0;
            end
        end
    end

    // Next-state logic and strobe decode from the registered state.
    always_comb begin
        state_s     = state_r;
        bus.dec_en  = 1'b0;
        bus.pc_clr  = 1'b0;
        bus.pc_inc  = 1'b0;
        bus.pc_ld   = 1'b0;
        bus.mar_ld  = 1'b0;
        bus.mem_rd  = 1'b0;
        bus.ir_ld   = 1'b0;
        bus.imm_ld  = 1'b0;
        bus.reg_we  = 1'b0;
        bus.reg_sel = 2'd0;
        bus.alu_oe  = 1'b0;
        bus.alu_sub = 1'b0;
        bus.flag_ld = 1'b0;
        bus.in_oe   = 1'b0;
        bus.imm_oe  = 1'b0;
        bus.out_ld  = 1'b0;
        bus.busy    = 1'b0;
        bus.halted  = 1'b0;
        bus.illegal = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (bus.start) begin
                    // Gated by rst so no pc_clr escapes while reset is held.
                    bus.pc_clr = ~rst;
                    state_s    = S_FETCH;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_FETCH: begin
                bus.busy   = 1'b1;
                bus.mar_ld = 1'b1;
                state_s    = S_LATCH;
            end
            S_LATCH: begin
                bus.busy   = 1'b1;
                bus.mem_rd = 1'b1;
                if (mem_last_s) begin
                    bus.ir_ld  = 1'b1;
                    bus.pc_inc = 1'b1;
                    state_s    = S_DECODE;
                end else begin
                    state_s = S_LATCH;
                end
            end
            S_DECODE: begin
                bus.busy   = 1'b1;
                bus.dec_en = 1'b1;
                if (flag_cnt_s == 4'd0) begin
                    state_s = S_FETCH;
                end else if (flag_cnt_s > 4'd1) begin
                    bus.illegal = 1'b1;
                    state_s     = S_HALT;
                end else if (bus.halt) begin
                    state_s = S_HALT;
                end else if (has_opnd_s) begin
                    // Operand sits at the already-incremented PC.
                    bus.mar_ld = 1'b1;
                    state_s    = S_OPND;
                end else begin
                    state_s = S_EXEC;
                end
            end
            S_OPND: begin
                bus.busy   = 1'b1;
                bus.mem_rd = 1'b1;
                if (mem_last_s) begin
                    bus.imm_ld = 1'b1;
                    bus.pc_inc = 1'b1;
                    state_s    = S_EXEC;
                end else begin
                    state_s = S_OPND;
                end
            end
            S_EXEC: begin
                bus.busy = 1'b1;
                if (op_r[OP_MOVA]) begin
                    bus.reg_we  = 1'b1;
                    bus.reg_sel = 2'd0;
                end else if (op_r[OP_MOVB]) begin
                    bus.reg_we  = 1'b1;
                    bus.reg_sel = 2'd1;
                end else if (op_r[OP_MOVC]) begin
                    bus.reg_we  = 1'b1;
                    bus.reg_sel = 2'd2;
                end else if (op_r[OP_MOVD]) begin
                    bus.reg_we  = 1'b1;
                    bus.reg_sel = 2'd3;
                end else if (op_r[OP_ADD] | op_r[OP_SUB]) begin
                    bus.alu_oe  = 1'b1;
                    bus.reg_we  = 1'b1;
                    bus.flag_ld = 1'b1;
                    bus.alu_sub = op_r[OP_SUB];
                end else if (op_r[OP_JMP]) begin
                    bus.pc_ld = 1'b1;
                end else if (op_r[OP_JG]) begin
                    bus.pc_ld = bus.gt;
                end else if (op_r[OP_IN1]) begin
                    bus.in_oe  = 1'b1;
                    bus.reg_we = 1'b1;
                end else if (op_r[OP_OUT1]) begin
                    bus.out_ld = 1'b1;
                end else if (op_r[OP_MOVI]) begin
                    bus.imm_oe = 1'b1;
                    bus.reg_we = 1'b1;
                end else begin
                    bus.reg_we = 1'b0;
                end
`ifdef SEQ_SINGLE_STEP_EN
                state_s = S_WAIT;
`else
                state_s = S_FETCH;
`endif
            end
            S_HALT: begin
                bus.halted = 1'b1;
                if (bus.start) begin
                    state_s = S_FETCH;
                end else begin
                    state_s = S_HALT;
                end
            end
`ifdef SEQ_SINGLE_STEP_EN
            S_WAIT: begin
                bus.busy = 1'b1;
                if (step_edge_s) begin
                    state_s = S_FETCH;
                end else begin
                    state_s = S_WAIT;
                end
            end
`endif
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end
endmodule
